// File: rtl/piso_ctrl_pkg.sv
// Shared types and default constants for the parallel-in/serial-out transmit controller.
package piso_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_GAP_CYCLES = 2;

    // Counter width that never collapses to zero bits for degenerate ranges.
    function automatic int safeClog2(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Left-shifting parallel-load register; the MSB is the serial output bit.
module piso_shreg
    import piso_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = d;
        end else if (shift) begin
            sh_d = {sh_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign msb = sh_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Framing controller: accepts a parallel word, serialises it MSB first with each
// bit held CLK_DIV clocks, then observes an optional inter-frame gap.
module piso_tx_ctrl
    import piso_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             abort,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             frame_sync,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = safeClog2(CLK_DIV);
    localparam int GW = safeClog2(GAP_CYCLES + 1);

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t state_q, state_d;

    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;

    logic ser_valid_q, ser_valid_d;
    logic frame_sync_q, frame_sync_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic             accept;
    logic             bit_end;
    logic             frame_end;
    logic             sh_load;
    logic             sh_shift;
    logic [WIDTH-1:0] sh_din;

    assign s_ready   = (state_q == IDLE) && !abort;
    assign accept    = s_valid && s_ready;
    assign bit_end   = (state_q == SHIFT) && (div_cnt_q == DIV_LAST);
    assign frame_end = bit_end && (bit_cnt_q == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (frame_end) begin
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (abort || (gap_cnt_q == GAP_LAST)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        gap_cnt_d = '0;
        if (accept) begin
            bit_cnt_d = '0;
            div_cnt_d = '0;
        end else if (state_q == SHIFT) begin
            if (abort || frame_end) begin
                bit_cnt_d = '0;
                div_cnt_d = '0;
            end else if (bit_end) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end else if ((state_q == GAP) && !abort && (gap_cnt_q != GAP_LAST)) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end
    end

    // The final shift empties the register so ser_data idles at 0; an abort reloads zeros.
    always_comb begin
        ser_valid_d  = (state_d == SHIFT);
        frame_sync_d = (state_d == SHIFT) && (bit_cnt_d == '0);
        busy_d       = (state_d != IDLE);
        done_d       = frame_end && !abort;
        sh_load      = accept || ((state_q != IDLE) && abort);
        sh_din       = accept ? s_data : '0;
        sh_shift     = bit_end && !abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            ser_valid_q  <= 1'b0;
            frame_sync_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            ser_valid_q  <= ser_valid_d;
            frame_sync_q <= frame_sync_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    piso_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sh_load),
        .shift (sh_shift),
        .d     (sh_din),
        .msb   (ser_data)
    );

    assign ser_valid  = ser_valid_q;
    assign frame_sync = frame_sync_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: four instances with different CLK_DIV/GAP settings,
// checked cycle by cycle against a frame-timeline model and a word scoreboard.
module tb_piso_tx_ctrl;

    localparam int N = 4;
    localparam int DIVS [N] = '{2, 1, 3, 4};
    localparam int GAPS [N] = '{3, 0, 1, 5};

    typedef struct {
        int         dut;
        logic [7:0] word;
        bit         hold;
        int         expValid;
        int         expSync;
        int         expDelay;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] sValid;
    logic [N-1:0] abortIn;
    logic [7:0]   sData [N];
    logic [N-1:0] sReady;
    logic [N-1:0] serData;
    logic [N-1:0] serValid;
    logic [N-1:0] frameSync;
    logic [N-1:0] busyOut;
    logic [N-1:0] doneOut;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    piso_tx_ctrl #(.WIDTH(8), .CLK_DIV(2), .GAP_CYCLES(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_valid(sValid[0]), .s_ready(sReady[0]),
        .s_data(sData[0]), .abort(abortIn[0]), .ser_data(serData[0]),
        .ser_valid(serValid[0]), .frame_sync(frameSync[0]), .busy(busyOut[0]),
        .done(doneOut[0]));

    piso_tx_ctrl #(.WIDTH(8), .CLK_DIV(1), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(sValid[1]), .s_ready(sReady[1]),
        .s_data(sData[1]), .abort(abortIn[1]), .ser_data(serData[1]),
        .ser_valid(serValid[1]), .frame_sync(frameSync[1]), .busy(busyOut[1]),
        .done(doneOut[1]));

    piso_tx_ctrl #(.WIDTH(8), .CLK_DIV(3), .GAP_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_valid(sValid[2]), .s_ready(sReady[2]),
        .s_data(sData[2]), .abort(abortIn[2]), .ser_data(serData[2]),
        .ser_valid(serValid[2]), .frame_sync(frameSync[2]), .busy(busyOut[2]),
        .done(doneOut[2]));

    piso_tx_ctrl #(.WIDTH(8), .CLK_DIV(4), .GAP_CYCLES(5)) dut3 (
        .clk(clk), .rst_n(rst_n), .s_valid(sValid[3]), .s_ready(sReady[3]),
        .s_data(sData[3]), .abort(abortIn[3]), .ser_data(serData[3]),
        .ser_valid(serValid[3]), .frame_sync(frameSync[3]), .busy(busyOut[3]),
        .done(doneOut[3]));

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, int'(actual), int'(expected));
    endtask

    task automatic applyStimulus(input int d, input logic v, input logic [7:0] w, input logic ab);
        sValid[d]  = v;
        sData[d]   = w;
        abortIn[d] = ab;
    endtask

    // Expected outputs k cycles after the accepting edge, from the frame timeline alone.
    task automatic checkCycle(input int d, input logic [7:0] word, input int k);
        int   bits;
        logic expValid, expData, expSync, expDone, expBusy;
        bits     = 8 * DIVS[d];
        expValid = (k >= 1) && (k <= bits);
        expData  = expValid ? word[7 - (k - 1) / DIVS[d]] : 1'b0;
        expSync  = (k >= 1) && (k <= DIVS[d]);
        expDone  = (k == bits + 1);
        expBusy  = (k <= bits + GAPS[d]);
        checkBit($sformatf("ser_valid d%0d k%0d", d, k), serValid[d], expValid);
        checkBit($sformatf("ser_data d%0d k%0d", d, k), serData[d], expData);
        checkBit($sformatf("frame_sync d%0d k%0d", d, k), frameSync[d], expSync);
        checkBit($sformatf("done d%0d k%0d", d, k), doneOut[d], expDone);
        checkBit($sformatf("busy d%0d k%0d", d, k), busyOut[d], expBusy);
        checkBit($sformatf("s_ready d%0d k%0d", d, k), sReady[d], !expBusy);
    endtask

    task automatic checkAllZero(input int d, input string tag);
        checkBit($sformatf("%s ser_data d%0d", tag, d), serData[d], 1'b0);
        checkBit($sformatf("%s ser_valid d%0d", tag, d), serValid[d], 1'b0);
        checkBit($sformatf("%s frame_sync d%0d", tag, d), frameSync[d], 1'b0);
        checkBit($sformatf("%s busy d%0d", tag, d), busyOut[d], 1'b0);
        checkBit($sformatf("%s done d%0d", tag, d), doneOut[d], 1'b0);
    endtask

    // Called at a negedge with the DUT ready; returns at the negedge of the first ready cycle.
    task automatic runFrame(input int d, input logic [7:0] word, input bit hold,
                            output int validCycles, output int syncCycles,
                            output int readyDelay, output logic [7:0] rebuilt);
        int total;
        int run;
        int doneK;
        total       = 8 * DIVS[d] + GAPS[d] + 1;
        run         = 0;
        doneK       = -1;
        readyDelay  = -1;
        validCycles = 0;
        syncCycles  = 0;
        rebuilt     = '0;
        applyStimulus(d, 1'b1, word, 1'b0);
        checkBit($sformatf("s_ready before accept d%0d", d), sReady[d], 1'b1);
        @(negedge clk);
        applyStimulus(d, hold, 8'($urandom), 1'b0);
        for (int k = 1; k <= total; k++) begin
            checkCycle(d, word, k);
            if (serValid[d]) begin
                validCycles++;
                if ((run % DIVS[d]) == (DIVS[d] / 2)) begin
                    rebuilt = {rebuilt[6:0], serData[d]};
                end
                run++;
            end
            if (frameSync[d]) syncCycles++;
            if (doneOut[d] && (doneK < 0)) doneK = k;
            if (sReady[d] && (doneK >= 0) && (readyDelay < 0)) readyDelay = k - doneK;
            if (k < total) begin
                sData[d] = 8'($urandom);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs [5];
        int         vc, sc, rd;
        logic [7:0] rb;
        logic [7:0] word;
        logic [7:0] sent [$];

        vecs[0] = '{0, 8'hA5, 1'b0, 16, 2, 3};
        vecs[1] = '{1, 8'hFF, 1'b1,  8, 1, 0};
        vecs[2] = '{1, 8'h00, 1'b0,  8, 1, 0};
        vecs[3] = '{2, 8'h5A, 1'b0, 24, 3, 1};
        vecs[4] = '{3, 8'hC3, 1'b0, 32, 4, 5};

        rst_n = 1'b0;
        for (int d = 0; d < N; d++) applyStimulus(d, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < N; d++) checkAllZero(d, "reset");
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < N; d++) checkBit($sformatf("s_ready after reset d%0d", d), sReady[d], 1'b1);

        $display("[TB] abort while idle blocks acceptance");
        applyStimulus(0, 1'b1, 8'h77, 1'b1);
        #1;
        checkBit("idle abort s_ready", sReady[0], 1'b0);
        @(negedge clk);
        checkBit("idle abort busy", busyOut[0], 1'b0);
        checkBit("idle abort ser_valid", serValid[0], 1'b0);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);

        $display("[TB] directed frame table");
        for (int i = 0; i < 5; i++) begin
            runFrame(vecs[i].dut, vecs[i].word, vecs[i].hold, vc, sc, rd, rb);
            checkOutput($sformatf("vec%0d valid cycles", i), vc, vecs[i].expValid);
            checkOutput($sformatf("vec%0d sync cycles", i), sc, vecs[i].expSync);
            checkOutput($sformatf("vec%0d ready delay", i), rd, vecs[i].expDelay);
            checkOutput($sformatf("vec%0d word", i), int'(rb), int'(vecs[i].word));
        end
        applyStimulus(1, 1'b0, 8'h00, 1'b0);

        $display("[TB] abort at bit 3");
        applyStimulus(0, 1'b1, 8'h81, 1'b0);
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            checkCycle(0, 8'h81, k);
            if (k < 7) @(negedge clk);
        end
        abortIn[0] = 1'b1;
        @(negedge clk);
        abortIn[0] = 1'b0;
        #1;
        checkAllZero(0, "after abort");
        checkBit("after abort s_ready", sReady[0], 1'b1);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkBit($sformatf("no done after abort %0d", k), doneOut[0], 1'b0);
            checkBit($sformatf("idle after abort %0d", k), busyOut[0], 1'b0);
            @(negedge clk);
        end
        runFrame(0, 8'h3C, 1'b0, vc, sc, rd, rb);
        checkOutput("post-abort word", int'(rb), 8'h3C);
        checkOutput("post-abort valid cycles", vc, 16);

        $display("[TB] reset mid-frame at bit 5");
        applyStimulus(0, 1'b1, 8'hF0, 1'b0);
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            checkCycle(0, 8'hF0, k);
            if (k < 11) @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero(0, "async reset");
        @(negedge clk);
        checkBit("reset held done", doneOut[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        checkBit("s_ready after release", sReady[0], 1'b1);
        runFrame(0, 8'h0F, 1'b0, vc, sc, rd, rb);
        checkOutput("post-reset word", int'(rb), 8'h0F);
        checkOutput("post-reset valid cycles", vc, 16);

        $display("[TB] randomized frames");
        for (int d = 1; d < N; d++) begin
            for (int n = 0; n < 6; n++) begin
                int idle;
                idle = $urandom_range(0, 2);
                for (int j = 0; j < idle; j++) @(negedge clk);
                word = 8'($urandom);
                sent.push_back(word);
                runFrame(d, word, 1'b0, vc, sc, rd, rb);
                checkOutput($sformatf("random d%0d n%0d word", d, n), int'(rb), int'(sent.pop_front()));
                checkOutput($sformatf("random d%0d n%0d valid cycles", d, n), vc, 8 * DIVS[d]);
                checkOutput($sformatf("random d%0d n%0d ready delay", d, n), rd, GAPS[d]);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
